// File: rtl/mem_req_sequencer.sv
// ============================================================================
// Module   : mem_req_sequencer
// Brief    : Front-end request sequencer of the memory controller. Accepts one
//            read/write request over a valid/ready handshake, splits the
//            address into a 3-bit bank select (to the 3-to-8 bank decoder) and
//            an in-bank offset, runs SETUP / ACCESS (with WAIT_CYCLES extra
//            access cycles) and returns the result over a response handshake.
// Options  : `define MEM_TXN_COUNT_EN to enable the completed-transaction
//            counter on txn_count; otherwise txn_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_sequencer #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [2:0]        bank_sel,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [15:0]       txn_count
);

  // Wait counter needs at least one bit even when no wait states are used.
  localparam int c_cnt_w = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_setup  = 2'd1;
  localparam logic [1:0] c_st_access = 2'd2;
  localparam logic [1:0] c_st_resp   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_we;
  logic               w_accept;
  logic               w_last;

  assign w_accept = (r_state == c_st_idle) && req_valid && req_ready;
  assign w_last   = (r_cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:   if (w_accept)  w_next_state = c_st_setup;
      c_st_setup:                 w_next_state = c_st_access;
      c_st_access: if (w_last)    w_next_state = c_st_resp;
      c_st_resp:   if (rsp_ready) w_next_state = c_st_idle;
      default:                    w_next_state = c_st_idle;
    endcase
  end

  // Registered outputs, request latch and wait counter, driven per state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready <= 1'b0;
      bank_sel  <= 3'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            bank_sel  <= req_addr[ADDR_W-1 -: 3];
            mem_addr  <= req_addr[ADDR_W-4:0];
            mem_wdata <= req_wdata;
            r_we      <= req_we;
            req_ready <= 1'b0;
          end else begin
            // Also raises ready on the first edge after reset release.
            req_ready <= 1'b1;
          end
        end
        c_st_setup: begin
          // Address/bank were stable for this cycle; start the access.
          r_cnt  <= c_cnt_w'(WAIT_CYCLES);
          mem_en <= 1'b1;
          mem_we <= r_we;
        end
        c_st_access: begin
          if (w_last) begin
            rsp_rdata <= r_we ? '0 : mem_rdata;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        c_st_resp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_TXN_COUNT_EN
  // Count completed response handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txn_count <= 16'd0;
    end else if (rsp_valid && rsp_ready) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`else
  assign txn_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_req_sequencer.sv
// ============================================================================
// Module   : tb_mem_req_sequencer
// Brief    : Self-checking bench for mem_req_sequencer. A WAIT_CYCLES=2
//            instance is driven from a per-cycle vector table plus a reset
//            abort sequence; a WAIT_CYCLES=0 instance runs back-to-back reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_req_sequencer;

`ifdef MEM_TXN_COUNT_EN
  localparam int c_txn_on = 1;
`else
  localparam int c_txn_on = 0;
`endif

  logic        clk;
  logic        rst_n;

  // Instance A: WAIT_CYCLES = 2
  logic        a_valid, a_we, a_rr;
  logic [10:0] a_addr;
  logic [7:0]  a_wdata, a_rdata;
  logic        a_ready, a_mwe, a_men, a_rspv;
  logic [2:0]  a_bank;
  logic [7:0]  a_maddr, a_mwd, a_rspd;
  logic [15:0] a_txn;

  // Instance B: WAIT_CYCLES = 0
  logic        b_valid, b_we, b_rr;
  logic [10:0] b_addr;
  logic [7:0]  b_wdata, b_rdata;
  logic        b_ready, b_mwe, b_men, b_rspv;
  logic [2:0]  b_bank;
  logic [7:0]  b_maddr, b_mwd, b_rspd;
  logic [15:0] b_txn;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_req_sequencer #(.ADDR_W(11), .DATA_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .bank_sel(a_bank), .mem_addr(a_maddr), .mem_wdata(a_mwd),
    .mem_we(a_mwe), .mem_en(a_men), .mem_rdata(a_rdata),
    .rsp_valid(a_rspv), .rsp_ready(a_rr), .rsp_rdata(a_rspd),
    .txn_count(a_txn)
  );

  mem_req_sequencer #(.ADDR_W(11), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .bank_sel(b_bank), .mem_addr(b_maddr), .mem_wdata(b_mwd),
    .mem_we(b_mwe), .mem_en(b_men), .mem_rdata(b_rdata),
    .rsp_valid(b_rspv), .rsp_ready(b_rr), .rsp_rdata(b_rspd),
    .txn_count(b_txn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied for one cycle, expected outputs just after that edge.
  typedef struct packed {
    logic        rv;
    logic        we;
    logic [10:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic        rr;
    logic        e_rdy;
    logic [2:0]  e_bank;
    logic [7:0]  e_maddr;
    logic [7:0]  e_mwd;
    logic        e_mwe;
    logic        e_men;
    logic        e_rspv;
    logic [7:0]  e_rspd;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, done, men_cyc, overlap, last_acc, cyc, bad;
    logic pre_acc, pre_done;

    //        rv we addr    wd     rd     rr   rdy bank  maddr  mwd    mwe men rspv rspd
    // write 0x5A3 / 0xC7 : bank 5, offset A3
    vecs[0]  = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b1,3'd0,8'h00,8'h00,1'b0,1'b0,1'b0,8'h00};
    vecs[1]  = '{1'b1,1'b1,11'h5A3,8'hC7,8'h00,1'b0, 1'b0,3'd5,8'hA3,8'hC7,1'b0,1'b0,1'b0,8'h00};
    vecs[2]  = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b0,3'd5,8'hA3,8'hC7,1'b1,1'b1,1'b0,8'h00};
    vecs[3]  = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b0,3'd5,8'hA3,8'hC7,1'b1,1'b1,1'b0,8'h00};
    vecs[4]  = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b0,3'd5,8'hA3,8'hC7,1'b1,1'b1,1'b0,8'h00};
    vecs[5]  = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b0,3'd5,8'hA3,8'hC7,1'b0,1'b0,1'b1,8'h00};
    // request presented while in RESP is ignored
    vecs[6]  = '{1'b1,1'b0,11'h7FF,8'h55,8'h00,1'b1, 1'b1,3'd5,8'hA3,8'hC7,1'b0,1'b0,1'b0,8'h00};
    // read 0x7FF : bank 7, offset FF, data 0x3C on final access edge
    vecs[7]  = '{1'b1,1'b0,11'h7FF,8'h55,8'h00,1'b0, 1'b0,3'd7,8'hFF,8'h55,1'b0,1'b0,1'b0,8'h00};
    vecs[8]  = '{1'b0,1'b0,11'h000,8'h00,8'hAA,1'b0, 1'b0,3'd7,8'hFF,8'h55,1'b0,1'b1,1'b0,8'h00};
    vecs[9]  = '{1'b0,1'b0,11'h000,8'h00,8'h3C,1'b0, 1'b0,3'd7,8'hFF,8'h55,1'b0,1'b1,1'b0,8'h00};
    vecs[10] = '{1'b0,1'b0,11'h000,8'h00,8'h3C,1'b0, 1'b0,3'd7,8'hFF,8'h55,1'b0,1'b1,1'b0,8'h00};
    vecs[11] = '{1'b0,1'b0,11'h000,8'h00,8'h3C,1'b0, 1'b0,3'd7,8'hFF,8'h55,1'b0,1'b0,1'b1,8'h3C};
    vecs[12] = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b0,3'd7,8'hFF,8'h55,1'b0,1'b0,1'b1,8'h3C};
    vecs[13] = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b0,3'd7,8'hFF,8'h55,1'b0,1'b0,1'b1,8'h3C};
    vecs[14] = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b0,3'd7,8'hFF,8'h55,1'b0,1'b0,1'b1,8'h3C};
    vecs[15] = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b1, 1'b1,3'd7,8'hFF,8'h55,1'b0,1'b0,1'b0,8'h3C};
    vecs[16] = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b0, 1'b1,3'd7,8'hFF,8'h55,1'b0,1'b0,1'b0,8'h3C};
    // write 0x0B5 / 0x96 with rsp_ready already high: data cleared, 1 cycle in RESP
    vecs[17] = '{1'b1,1'b1,11'h0B5,8'h96,8'hE1,1'b1, 1'b0,3'd0,8'hB5,8'h96,1'b0,1'b0,1'b0,8'h3C};
    vecs[18] = '{1'b0,1'b0,11'h000,8'h00,8'hE1,1'b1, 1'b0,3'd0,8'hB5,8'h96,1'b1,1'b1,1'b0,8'h3C};
    vecs[19] = '{1'b0,1'b0,11'h000,8'h00,8'hE1,1'b1, 1'b0,3'd0,8'hB5,8'h96,1'b1,1'b1,1'b0,8'h3C};
    vecs[20] = '{1'b0,1'b0,11'h000,8'h00,8'hE1,1'b1, 1'b0,3'd0,8'hB5,8'h96,1'b1,1'b1,1'b0,8'h3C};
    vecs[21] = '{1'b0,1'b0,11'h000,8'h00,8'hE1,1'b1, 1'b0,3'd0,8'hB5,8'h96,1'b0,1'b0,1'b1,8'h00};
    vecs[22] = '{1'b0,1'b0,11'h000,8'h00,8'h00,1'b1, 1'b1,3'd0,8'hB5,8'h96,1'b0,1'b0,1'b0,8'h00};

    rst_n = 1'b0;
    a_valid = 0; a_we = 0; a_rr = 0; a_addr = '0; a_wdata = '0; a_rdata = '0;
    b_valid = 0; b_we = 0; b_rr = 0; b_addr = '0; b_wdata = '0; b_rdata = '0;

    // ---- reset state, held over a few edges ----
    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", a_ready, 1'b0);
    check("rst.outputs", {a_bank, a_maddr, a_mwd, a_mwe, a_men, a_rspv, a_rspd}, '0);
    check("rst.txn_count", a_txn, 16'd0);
    check("rst.dut0_req_ready", b_ready, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven transactions on the WAIT_CYCLES=2 instance ----
    for (int i = 0; i < 23; i++) begin
      a_valid = vecs[i].rv;  a_we = vecs[i].we;  a_addr = vecs[i].addr;
      a_wdata = vecs[i].wd;  a_rdata = vecs[i].rd; a_rr = vecs[i].rr;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.req_ready", i), a_ready,  vecs[i].e_rdy);
      check($sformatf("v%0d.bank_sel", i),  a_bank,   vecs[i].e_bank);
      check($sformatf("v%0d.mem_addr", i),  a_maddr,  vecs[i].e_maddr);
      check($sformatf("v%0d.mem_wdata", i), a_mwd,    vecs[i].e_mwd);
      check($sformatf("v%0d.mem_we", i),    a_mwe,    vecs[i].e_mwe);
      check($sformatf("v%0d.mem_en", i),    a_men,    vecs[i].e_men);
      check($sformatf("v%0d.rsp_valid", i), a_rspv,   vecs[i].e_rspv);
      check($sformatf("v%0d.rsp_rdata", i), a_rspd,   vecs[i].e_rspd);
      @(negedge clk);
    end
    check("txn_count.after3", a_txn, (c_txn_on != 0) ? 32'd3 : 32'd0);

    // ---- reset asserted during ACCESS of a write ----
    a_valid = 1; a_we = 1; a_addr = 11'h123; a_wdata = 8'h42; a_rr = 0;
    @(posedge clk);
    @(negedge clk);
    a_valid = 0;
    @(posedge clk);
    #1;
    check("abort.mem_en_before", a_men, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.mem_en_async", a_men, 1'b0);
    check("abort.outputs", {a_ready, a_bank, a_maddr, a_mwd, a_mwe, a_rspv, a_rspd}, '0);
    check("abort.txn_count", a_txn, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort.req_ready", a_ready, 1'b1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_rspv || a_men) bad++;
      @(posedge clk);
      #1;
    end
    check("abort.no_response", bad, 0);

    // ---- back-to-back reads on the WAIT_CYCLES=0 instance ----
    @(negedge clk);
    b_valid = 1; b_we = 0; b_addr = 11'h2C4; b_rr = 1; b_rdata = 8'h5E;
    acc = 0; done = 0; men_cyc = 0; overlap = 0; last_acc = -1; cyc = 0;
    while (done < 3 && cyc < 40) begin
      pre_acc  = b_valid && b_ready;
      pre_done = b_rspv && b_rr;
      if (pre_done) check($sformatf("b2b%0d.rsp_rdata", done), b_rspd, 8'h5E);
      @(posedge clk);
      #1;
      cyc++;
      if (pre_acc) begin
        if (last_acc >= 0) check($sformatf("b2b%0d.spacing", acc), cyc - last_acc, 4);
        last_acc = cyc;
        acc++;
      end
      if (pre_done) done++;
      if (b_men) men_cyc++;
      if (b_men && b_rspv) overlap++;
      @(negedge clk);
      if (acc >= 3) b_valid = 0;
      b_addr = b_addr + 11'd1;
    end
    check("b2b.responses", done, 3);
    check("b2b.accepts", acc, 3);
    check("b2b.mem_en_cycles", men_cyc, 3);
    check("b2b.overlap", overlap, 0);
    check("b2b.txn_count", b_txn, (c_txn_on != 0) ? 32'd3 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
